// File: rtl/alu_issue_stage.sv
// Decode-and-issue stage in front of the ALU: RV32IM ALU-field decode, operand
// formation, and a 2-entry in-order skid buffer toward the ALU.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2:0]      func,
    output logic [6:0]      funch,
    output logic [4:0]      mode,
    output logic [XLEN-1:0] ALUin1,
    output logic [XLEN-1:0] ALUin2,
    output logic [4:0]      rd,
    output logic            illegal
);

    localparam logic [4:0] MODE_OP    = 5'b01100;
    localparam logic [4:0] MODE_IMM   = 5'b00100;
    localparam logic [4:0] MODE_LUI   = 5'b01101;
    localparam logic [4:0] MODE_AUIPC = 5'b00101;

    typedef struct packed {
        logic            illegal;
        logic [2:0]      func;
        logic [6:0]      funch;
        logic [4:0]      mode;
        logic [4:0]      rd;
        logic [XLEN-1:0] a1;
        logic [XLEN-1:0] a2;
    } entry_t;

    entry_t     dec;
    entry_t     head_q;
    entry_t     skid_q;
    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       rdy_q;
    logic       legal;
    logic       acc;
    logic       pop;
    logic [2:0] f3;
    logic [6:0] f7;

    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];

    always_comb begin
        dec      = '0;
        dec.mode = in_instr[6:2];
        dec.rd   = in_instr[11:7];
        legal    = 1'b0;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:2])
                MODE_OP: begin
                    legal     = (f7 == 7'h00) || (f7 == 7'h01) ||
                                (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
                    dec.func  = f3;
                    dec.funch = f7;
                    dec.a1    = in_rs1;
                    dec.a2    = in_rs2;
                end
                MODE_IMM: begin
                    dec.func = f3;
                    dec.a1   = in_rs1;
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        legal     = (f7 == 7'h00) || (f3 == 3'b101 && f7 == 7'h20);
                        dec.funch = f7;
                        dec.a2    = {{(XLEN-5){1'b0}}, in_instr[24:20]};
                    end else begin
                        legal  = 1'b1;
                        dec.a2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
                    end
                end
                MODE_LUI: begin
                    legal  = 1'b1;
                    dec.a2 = {in_instr[31:12], 12'b0};
                end
                MODE_AUIPC: begin
                    legal  = 1'b1;
                    dec.a1 = in_pc;
                    dec.a2 = {in_instr[31:12], 12'b0};
                end
                default: legal = 1'b0;
            endcase
        end
        // Unsupported encodings still issue, but with neutral control and operands.
        if (!legal) begin
            dec.func  = '0;
            dec.funch = '0;
            dec.a1    = '0;
            dec.a2    = '0;
        end
        dec.illegal = !legal;
    end

    assign acc = in_valid && rdy_q && !flush;
    assign pop = (cnt_q != 2'd0) && out_ready && !flush;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = 2'd0;
        end else begin
            case ({acc, pop})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b1;
            head_q <= '0;
            skid_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
            if (!flush) begin
                // New entry goes to head when it would otherwise be empty; skid only
                // ever holds the second-oldest entry.
                if (acc && (cnt_q == 2'd0 || pop))
                    head_q <= dec;
                else if (pop && cnt_q == 2'd2)
                    head_q <= skid_q;
                if (acc && cnt_q == 2'd1 && !pop)
                    skid_q <= dec;
            end
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (cnt_q != 2'd0);
    assign illegal   = head_q.illegal;
    assign func      = head_q.func;
    assign funch     = head_q.funch;
    assign mode      = head_q.mode;
    assign rd        = head_q.rd;
    assign ALUin1    = head_q.a1;
    assign ALUin2    = head_q.a2;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed decode cases plus randomized
// traffic against a queue-based reference model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic        ill;
        logic [2:0]  func;
        logic [6:0]  funch;
        logic [4:0]  mode;
        logic [4:0]  rd;
        logic [31:0] a1;
        logic [31:0] a2;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [31:0] in_pc = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  func;
    logic [6:0]  funch;
    logic [4:0]  mode;
    logic [31:0] ALUin1;
    logic [31:0] ALUin2;
    logic [4:0]  rd;
    logic        illegal;

    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    alu_issue_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .func(func), .funch(funch), .mode(mode),
        .ALUin1(ALUin1), .ALUin2(ALUin2), .rd(rd), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic ent_t sample();
        return {illegal, func, funch, mode, rd, ALUin1, ALUin2};
    endfunction

    // Reference decode from opcode values and arithmetic on the instruction word.
    function automatic ent_t ref_decode(logic [31:0] ins, logic [31:0] r1,
                                        logic [31:0] r2, logic [31:0] pc);
        ent_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.mode = ins[6:2];
        e.rd = ins[11:7];
        e.ill = 1'b1;
        case (op)
            7'h33: if (f7 == 0 || f7 == 1 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                e.ill = 0; e.func = f3; e.funch = f7; e.a1 = r1; e.a2 = r2;
            end
            7'h13: begin
                if (f3 == 1 || f3 == 5) begin
                    if (f7 == 0 || (f3 == 5 && f7 == 7'h20)) begin
                        e.ill = 0; e.func = f3; e.funch = f7; e.a1 = r1;
                        e.a2 = (ins >> 20) & 32'd31;
                    end
                end else begin
                    e.ill = 0; e.func = f3; e.a1 = r1;
                    e.a2 = $signed(ins) >>> 20;
                end
            end
            7'h37: begin e.ill = 0; e.a2 = ins & 32'hFFFFF000; end
            7'h17: begin e.ill = 0; e.a1 = pc; e.a2 = ins & 32'hFFFFF000; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  f7s [4];
        f7s[0] = 7'h00; f7s[1] = 7'h01; f7s[2] = 7'h20; f7s[3] = 7'($urandom);
        ins = $urandom;
        case ($urandom_range(0, 5))
            0: begin ins[6:0] = 7'h33; ins[31:25] = f7s[$urandom_range(0, 3)]; end
            1: begin ins[6:0] = 7'h13; if ($urandom_range(0, 1) == 1) ins[31:25] = f7s[$urandom_range(0, 3)]; end
            2: ins[6:0] = 7'h37;
            3: ins[6:0] = 7'h17;
            4: ins[1:0] = 2'b11;
            default: ;
        endcase
        return ins;
    endfunction

    // Advance the model by one edge using the current inputs, then move to the
    // next falling edge where outputs are sampled.
    task automatic tick();
        bit acc, pop;
        acc = in_valid && (mq.size() < 2) && !flush;
        pop = (mq.size() > 0) && out_ready && !flush;
        if (flush) mq.delete();
        else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(ref_decode(in_instr, in_rs1, in_rs2, in_pc));
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(logic [31:0] ins, logic [31:0] r1, logic [31:0] r2, logic [31:0] pc);
        in_instr = ins; in_rs1 = r1; in_rs2 = r2; in_pc = pc;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_hs: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        else checks += 0;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) errors++;
        checks++;
        if (sample() !== ent_t'(0)) begin
            errors++;
            $display("FAIL reset_fields: got %h, required 0", sample());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_decode();
        ent_t exp;
        ent_t got;
        logic [31:0] ins [6];
        logic [31:0] r1s [6];
        ent_t        exps [6];
        ins[0] = 32'h002081B3; r1s[0] = 32'd5;
        exps[0] = {1'b0, 3'b000, 7'h00, 5'b01100, 5'd3, 32'd5, 32'd7};
        ins[1] = 32'hFFF08093; r1s[1] = 32'd10;
        exps[1] = {1'b0, 3'b000, 7'h00, 5'b00100, 5'd1, 32'd10, 32'hFFFFFFFF};
        ins[2] = 32'h4030D093; r1s[2] = 32'd10;
        exps[2] = {1'b0, 3'b101, 7'h20, 5'b00100, 5'd1, 32'd10, 32'd3};
        ins[3] = 32'h12345297; r1s[3] = 32'd9;
        exps[3] = {1'b0, 3'b000, 7'h00, 5'b00101, 5'd5, 32'h100, 32'h12345000};
        ins[4] = 32'h04208133; r1s[4] = 32'd5;
        exps[4] = {1'b1, 3'b000, 7'h00, 5'b01100, 5'd2, 32'd0, 32'd0};
        ins[5] = 32'h00000000; r1s[5] = 32'd5;
        exps[5] = {1'b1, 3'b000, 7'h00, 5'b00000, 5'd0, 32'd0, 32'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(ins[i], r1s[i], 32'd7, 32'h100);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            exp = exps[i];
            got = sample();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL decode_valid[%0d]: out_valid=%b, required 1", i, out_valid);
            end
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL decode[%0d] instr=%h: got %h, required %h", i, ins[i], got, exp);
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int          nxt = 0;
        logic [31:0] got[$];
        for (int cyc = 0; cyc < 20 && got.size() < 5; cyc++) begin
            in_valid = (nxt < 5);
            drive(32'h002081B3, 32'(nxt + 1), 32'h77, 32'h0);
            out_ready = (cyc >= 4);
            if (out_valid && out_ready) got.push_back(ALUin1);
            if (in_valid && mq.size() < 2) nxt++;
            tick();
            if (cyc == 1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_full: in_ready=%b after two accepts, required 0", in_ready);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 5) begin
            errors++;
            $display("FAIL bp_count: delivered %0d, required 5", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== 32'(i + 1)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %0d, required %0d", i, got[i], i + 1);
            end
        end
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(32'h002081B3, 32'(40 + i), 32'h3, 32'h0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        fill_two();
        drive(32'h002081B3, 32'd99, 32'd99, 32'h0);
        in_valid = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_ghost: out_valid=%b ALUin1=%0d, required idle", out_valid, ALUin1);
            end
        end
    endtask

    task automatic test_reset_midstream();
        fill_two();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sample() !== ent_t'(0)) begin
            errors++;
            $display("FAIL rst_mid: out_valid=%b in_ready=%b fields=%h, required 0/1/0",
                     out_valid, in_ready, sample());
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ghost: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 49) == 0);
            drive(rand_instr(), $urandom, $urandom, $urandom);
            tick();
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                errors++;
                $display("FAIL rand_hs[%0d]: out_valid=%b in_ready=%b, required %b/%b",
                         cyc, out_valid, in_ready, mq.size() > 0, mq.size() < 2);
            end
            if (mq.size() > 0) begin
                checks++;
                if (sample() !== mq[0]) begin
                    errors++;
                    $display("FAIL rand_head[%0d]: got %h, required %h", cyc, sample(), mq[0]);
                end
            end
        end
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode-and-issue stage that sits in front of the ALU. It accepts a 32-bit RV32IM instruction with its register operands and PC over a valid/ready handshake, and decodes the ALU control fields (`func`, `funch`, `mode`). It selects and forms the two ALU operands and presents them, registered, to the ALU through a 2-entry skid buffer. Full throughput is one instruction per cycle; downstream backpressure is absorbed without loss.

## Interface
- `XLEN`, 32: operand width; fixed at 32, not re-targetable.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: upstream has an instruction.
- `in_ready` output 1: stage can accept; registered.
- `in_instr` input 32: instruction word.
- `in_rs1` input 32: rs1 register value.
- `in_rs2` input 32: rs2 register value.
- `in_pc` input 32: instruction address.
- `flush` input 1: synchronous kill of all buffered entries.
- `out_valid` output 1: issue entry present.
- `out_ready` input 1: ALU side consumes the entry.
- `func` output 3: instr[14:12] or forced, see Operation.
- `funch` output 7: instr[31:25] or forced, see Operation.
- `mode` output 5: instr[6:2].
- `ALUin1` output 32: first operand.
- `ALUin2` output 32: second operand.
- `rd` output 5: instr[11:7] passthrough.
- `illegal` output 1: entry decoded as unsupported; still issued.

## Operation
- Accept when `in_valid && in_ready && !flush`. Decode is combinational on input; the result is written into the buffer.
- OP (mode 01100): `func`=instr[14:12], `funch`=instr[31:25], `ALUin1`=rs1, `ALUin2`=rs2. Legal `funch` values:
  - 0000000 with any `func`;
  - 0100000 with `func` 000 or 101;
  - 0000001 with any `func`.
  - Any other value sets `illegal`.
- OP-IMM (mode 00100): `ALUin1`=rs1.
  - `func` 001/101 (shifts): `ALUin2`={27'b0, instr[24:20]}, `funch`=instr[31:25]. Legal `funch`: 001 requires 0000000; 101 allows 0000000 or 0100000; otherwise `illegal`.
  - All other `func`: `ALUin2`=sign-extended instr[31:20], `funch`=0000000.
- LUI (01101): `func`=000, `funch`=0, `ALUin1`=0, `ALUin2`={instr[31:12],12'b0}.
- AUIPC (00101): as LUI but `ALUin1`=pc.
- Any other mode, or instr[1:0]≠11: `illegal`=1, `func`=0, `funch`=0, operands 0, `mode` still instr[6:2].
- Skid buffer: a 2-entry FIFO, main register plus skid register, with strict in-order delivery.
  - Outputs always come from the head entry.
  - `in_ready` = (occupancy < 2), computed from registered occupancy.
  - Simultaneous accept and pop at occupancy 2 cannot occur, because `in_ready`=0.
  - At occupancy 1 with accept and pop in the same cycle: the new entry becomes head and occupancy stays 1.
- `flush`: occupancy goes to 0 at the next edge. `flush` overrides same-cycle accept (input dropped) and pop.

## Timing
- Reset (async assert, sync release on `clk`):
  - `out_valid`=0, `in_ready`=1, `illegal`=0;
  - `func`/`funch`/`mode`/`rd`=0, `ALUin1`/`ALUin2`=0;
  - occupancy 0.
- Latency: accepted at edge k → `out_valid`=1 with decoded fields after edge k.
- Throughput: 1/cycle while `out_ready`=1.
- Output stability: fields stay stable while `out_valid && !out_ready`.
- Empty outputs: with `out_valid`=0, fields hold their last values (don't-care for the consumer).
- `in_ready` drops the cycle after the second entry is held. It rises the cycle after a pop from full.
- Reset mid-stream: all entries are lost immediately and nothing is issued afterwards.

## Test plan
- ADD, `in_instr`=0x002081B3, rs1=5, rs2=7 → next cycle `out_valid`=1, `func`=000, `funch`=0000000, `mode`=01100, `ALUin1`=5, `ALUin2`=7, `rd`=3, `illegal`=0.
- Immediates:
  - ADDI imm=-1 (0xFFF08093), rs1=10 → `ALUin2`=0xFFFFFFFF, `funch`=0.
  - SRAI shamt 3 (0x4030D093) → `funch`=0100000, `func`=101, `ALUin2`=3.
  - AUIPC 0x12345 with pc=0x100 → `ALUin1`=0x100, `ALUin2`=0x12345000.
- Illegal cases:
  - OP with `funch`=0000010 → `illegal`=1, `func`/`funch`=0.
  - instr=0x00000000 → `illegal`=1.
- Backpressure: stream of 5 ADDs, `in_valid`=1 throughout, `out_ready`=0 for 4 cycles then 1 → `in_ready`=0 after 2 accepts; all 5 delivered in order, with no duplicates and no drops.
- Flush:
  - Flush with 2 entries held and `in_valid`=1 → next cycle `out_valid`=0, `in_ready`=1; the flushed-cycle input never appears.
  - Async `rst_n` pulse mid-stream → outputs zero immediately.
